// File: rtl/wb_arbiter_2m.sv
//==============================================================================
// Module   : wb_arbiter_2m
// Brief    : Two-master / one-slave Wishbone classic round-robin arbiter.
//            The grant is held for the whole CYC burst of the winning master,
//            and one idle cycle separates consecutive grants.
// Options  : WB_ARB_TIMEOUT_EN - abort slave cycles whose STB stalls for
//            TIMEOUT_CYCLES cycles, answering the master with a bus error.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module wb_arbiter_2m #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  i_clk,
   input  logic                  i_resetn,
   // master 0 (SPI bridge)
   input  logic [ADDR_W-1:0]     m0_wb_adr_i,
   input  logic [DATA_W-1:0]     m0_wb_dat_i,
   output logic [DATA_W-1:0]     m0_wb_dat_o,
   input  logic                  m0_wb_we_i,
   input  logic [DATA_W/8-1:0]   m0_wb_sel_i,
   input  logic                  m0_wb_stb_i,
   input  logic                  m0_wb_cyc_i,
   output logic                  m0_wb_ack_o,
   output logic                  m0_wb_err_o,
   // master 1 (control sequencer)
   input  logic [ADDR_W-1:0]     m1_wb_adr_i,
   input  logic [DATA_W-1:0]     m1_wb_dat_i,
   output logic [DATA_W-1:0]     m1_wb_dat_o,
   input  logic                  m1_wb_we_i,
   input  logic [DATA_W/8-1:0]   m1_wb_sel_i,
   input  logic                  m1_wb_stb_i,
   input  logic                  m1_wb_cyc_i,
   output logic                  m1_wb_ack_o,
   output logic                  m1_wb_err_o,
   // shared slave
   output logic [ADDR_W-1:0]     s_wb_adr_o,
   output logic [DATA_W-1:0]     s_wb_dat_o,
   input  logic [DATA_W-1:0]     s_wb_dat_i,
   output logic                  s_wb_we_o,
   output logic [DATA_W/8-1:0]   s_wb_sel_o,
   output logic                  s_wb_stb_o,
   output logic                  s_wb_cyc_o,
   input  logic                  s_wb_ack_i,
   input  logic                  s_wb_err_i,
   // status
   output logic [1:0]            o_grant,
   output logic                  o_busy,
   output logic                  o_timeout
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_GRANT = 2'd1,
      ST_ABORT = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   state_t     r_state;
   logic [1:0] r_grant;     // one-hot owner of the slave bus
   logic       r_last;      // 1: master 1 was granted most recently
   logic       r_timeout;   // high during the single ABORT cycle

   logic w_req0;
   logic w_req1;
   logic w_pick1;
   logic w_sel1;
   logic w_gcyc;
   logic w_gstb;
   logic w_in_grant;
   logic w_in_abort;
   logic w_expire;

   assign w_req0     = m0_wb_cyc_i & m0_wb_stb_i;
   assign w_req1     = m1_wb_cyc_i & m1_wb_stb_i;
   // on a tie the master that did not win last time goes first
   assign w_pick1    = w_req1 & (~w_req0 | ~r_last);
   assign w_sel1     = r_grant[1];
   assign w_gcyc     = w_sel1 ? m1_wb_cyc_i : m0_wb_cyc_i;
   assign w_gstb     = w_sel1 ? m1_wb_stb_i : m0_wb_stb_i;
   assign w_in_grant = (r_state == ST_GRANT);
   assign w_in_abort = (r_state == ST_ABORT);

   // slave side follows the owner combinationally; control is gated by state
   assign s_wb_adr_o = w_sel1 ? m1_wb_adr_i : m0_wb_adr_i;
   assign s_wb_dat_o = w_sel1 ? m1_wb_dat_i : m0_wb_dat_i;
   assign s_wb_sel_o = w_sel1 ? m1_wb_sel_i : m0_wb_sel_i;
   assign s_wb_we_o  = w_in_grant & (w_sel1 ? m1_wb_we_i : m0_wb_we_i);
   assign s_wb_cyc_o = w_in_grant & w_gcyc;
   assign s_wb_stb_o = w_in_grant & w_gstb;

   // read data is broadcast; handshakes reach only the owner
   assign m0_wb_dat_o = s_wb_dat_i;
   assign m1_wb_dat_o = s_wb_dat_i;
   assign m0_wb_ack_o = w_in_grant & r_grant[0] & s_wb_ack_i;
   assign m1_wb_ack_o = w_in_grant & r_grant[1] & s_wb_ack_i;
   assign m0_wb_err_o = r_grant[0] & ((w_in_grant & s_wb_err_i) | w_in_abort);
   assign m1_wb_err_o = r_grant[1] & ((w_in_grant & s_wb_err_i) | w_in_abort);

   assign o_grant   = r_grant;
   assign o_busy    = (r_state != ST_IDLE);
   assign o_timeout = r_timeout;

`ifdef WB_ARB_TIMEOUT_EN
   localparam int                 c_CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYCLES - 1);

   logic [c_CNT_W-1:0] r_cnt;
   logic               w_stall;

   // a stall is a strobed slave cycle with no response; ACK/ERR beats expiry
   assign w_stall  = s_wb_stb_o & ~s_wb_ack_i & ~s_wb_err_i;
   assign w_expire = w_stall & w_gcyc & (r_cnt == c_CNT_LAST);

   // count consecutive stall cycles, clearing on any response or idle strobe
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_cnt <= '0;
      end else if (w_stall & w_gcyc & ~w_expire) begin
         r_cnt <= r_cnt + 1'b1;
      end else begin
         r_cnt <= '0;
      end
   end
`else
   logic [31:0] w_unused_timeout;
   assign w_unused_timeout = 32'(TIMEOUT_CYCLES);
   assign w_expire         = 1'b0;
`endif

   // arbitration state machine with registered grant and timeout pulse
   always_ff @(posedge i_clk or negedge i_resetn) begin
      if (!i_resetn) begin
         r_state   <= ST_IDLE;
         r_grant   <= 2'b00;
         r_last    <= 1'b1;
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_req0 | w_req1) begin
                  r_grant <= w_pick1 ? 2'b10 : 2'b01;
                  r_last  <= w_pick1;
                  r_state <= ST_GRANT;
               end
            end
            ST_GRANT: begin
               if (!w_gcyc) begin
                  r_grant <= 2'b00;
                  r_state <= ST_IDLE;
               end else if (w_expire) begin
                  r_timeout <= 1'b1;
                  r_state   <= ST_ABORT;
               end
            end
            ST_ABORT: begin
               r_state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (!w_gcyc) begin
                  r_grant <= 2'b00;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_grant <= 2'b00;
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter_2m.sv
//==============================================================================
// Module   : tb_wb_arbiter_2m
// Brief    : Self-checking bench for wb_arbiter_2m (scenario tasks plus a
//            randomized run against a transaction-level ownership model).
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_wb_arbiter_2m;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW/8;
`ifdef WB_ARB_TIMEOUT_EN
   localparam int TO = 8;
`else
   localparam int TO = 255;
`endif

   logic i_clk    = 1'b0;
   logic i_resetn = 1'b0;
   logic [AW-1:0] m0_wb_adr_i, m1_wb_adr_i, s_wb_adr_o;
   logic [DW-1:0] m0_wb_dat_i, m1_wb_dat_i, m0_wb_dat_o, m1_wb_dat_o;
   logic [DW-1:0] s_wb_dat_o, s_wb_dat_i;
   logic [SW-1:0] m0_wb_sel_i, m1_wb_sel_i, s_wb_sel_o;
   logic m0_wb_we_i, m0_wb_stb_i, m0_wb_cyc_i, m0_wb_ack_o, m0_wb_err_o;
   logic m1_wb_we_i, m1_wb_stb_i, m1_wb_cyc_i, m1_wb_ack_o, m1_wb_err_o;
   logic s_wb_we_o, s_wb_stb_o, s_wb_cyc_o, s_wb_ack_i, s_wb_err_i;
   logic [1:0] o_grant;
   logic o_busy, o_timeout;

   int checks = 0;
   int errors = 0;

   always #5 i_clk = ~i_clk;

   wb_arbiter_2m #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
      .i_clk(i_clk), .i_resetn(i_resetn),
      .m0_wb_adr_i(m0_wb_adr_i), .m0_wb_dat_i(m0_wb_dat_i), .m0_wb_dat_o(m0_wb_dat_o),
      .m0_wb_we_i(m0_wb_we_i), .m0_wb_sel_i(m0_wb_sel_i), .m0_wb_stb_i(m0_wb_stb_i),
      .m0_wb_cyc_i(m0_wb_cyc_i), .m0_wb_ack_o(m0_wb_ack_o), .m0_wb_err_o(m0_wb_err_o),
      .m1_wb_adr_i(m1_wb_adr_i), .m1_wb_dat_i(m1_wb_dat_i), .m1_wb_dat_o(m1_wb_dat_o),
      .m1_wb_we_i(m1_wb_we_i), .m1_wb_sel_i(m1_wb_sel_i), .m1_wb_stb_i(m1_wb_stb_i),
      .m1_wb_cyc_i(m1_wb_cyc_i), .m1_wb_ack_o(m1_wb_ack_o), .m1_wb_err_o(m1_wb_err_o),
      .s_wb_adr_o(s_wb_adr_o), .s_wb_dat_o(s_wb_dat_o), .s_wb_dat_i(s_wb_dat_i),
      .s_wb_we_o(s_wb_we_o), .s_wb_sel_o(s_wb_sel_o), .s_wb_stb_o(s_wb_stb_o),
      .s_wb_cyc_o(s_wb_cyc_o), .s_wb_ack_i(s_wb_ack_i), .s_wb_err_i(s_wb_err_i),
      .o_grant(o_grant), .o_busy(o_busy), .o_timeout(o_timeout)
   );

   // outputs that must all be zero while reset is asserted
   wire [10:0] w_rst_vec = {o_grant, s_wb_cyc_o, s_wb_stb_o, s_wb_we_o, m0_wb_ack_o,
                            m0_wb_err_o, m1_wb_ack_o, m1_wb_err_o, o_busy, o_timeout};

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge i_clk);
   endtask

   task automatic drive_m(input int n, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                          input logic we, input logic [SW-1:0] sel, input logic req);
      if (n == 0) begin
         m0_wb_adr_i = adr; m0_wb_dat_i = dat; m0_wb_we_i = we; m0_wb_sel_i = sel;
         m0_wb_cyc_i = req; m0_wb_stb_i = req;
      end else begin
         m1_wb_adr_i = adr; m1_wb_dat_i = dat; m1_wb_we_i = we; m1_wb_sel_i = sel;
         m1_wb_cyc_i = req; m1_wb_stb_i = req;
      end
   endtask

   task automatic idle_all();
      drive_m(0, '0, '0, 1'b0, '0, 1'b0);
      drive_m(1, '0, '0, 1'b0, '0, 1'b0);
      s_wb_dat_i = '0; s_wb_ack_i = 1'b0; s_wb_err_i = 1'b0;
   endtask

   task automatic do_reset();
      i_resetn = 1'b0;
      idle_all();
      tick();
      tick();
      i_resetn = 1'b1;
   endtask

   task automatic test_reset();
      i_resetn = 1'b0;
      drive_m(0, 32'h1, 32'h2, 1'b1, 4'hF, 1'b1);
      drive_m(1, 32'h3, 32'h4, 1'b1, 4'hF, 1'b1);
      s_wb_ack_i = 1'b1; s_wb_err_i = 1'b1;
      #2;
      checks++;
      if (w_rst_vec !== 11'b0) begin
         errors++; $display("FAIL reset_outputs got=%b exp=%b", w_rst_vec, 11'b0);
      end
      tick(); tick();
      checks++;
      if (w_rst_vec !== 11'b0) begin
         errors++; $display("FAIL reset_held got=%b exp=%b", w_rst_vec, 11'b0);
      end
      idle_all();
      i_resetn = 1'b1;
   endtask

   task automatic test_single_write();
      int acks = 0;
      int m1acks = 0;
      do_reset();
      drive_m(0, 32'h4000_0010, 32'hDEAD_BEEF, 1'b1, 4'hF, 1'b1);
      at_neg();
      checks++;
      if (o_grant !== 2'b00) begin
         errors++; $display("FAIL sw_latency got=%b exp=%b", o_grant, 2'b00);
      end
      tick(); at_neg();
      checks++;
      if (o_grant !== 2'b01) begin
         errors++; $display("FAIL sw_grant got=%b exp=%b", o_grant, 2'b01);
      end
      checks++;
      if ({s_wb_adr_o, s_wb_dat_o, s_wb_sel_o, s_wb_we_o, s_wb_cyc_o, s_wb_stb_o, o_busy} !==
          {32'h4000_0010, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b1}) begin
         errors++; $display("FAIL sw_slave_bus got=%h/%h/%h/%b%b%b%b exp=40000010/deadbeef/f/1111",
                            s_wb_adr_o, s_wb_dat_o, s_wb_sel_o, s_wb_we_o, s_wb_cyc_o, s_wb_stb_o, o_busy);
      end
      acks += int'(m0_wb_ack_o); m1acks += int'(m1_wb_ack_o);
      for (int k = 0; k < 3; k++) begin
         tick();
         s_wb_ack_i = (k == 2);
         at_neg();
         acks += int'(m0_wb_ack_o); m1acks += int'(m1_wb_ack_o);
      end
      tick();
      s_wb_ack_i = 1'b0;
      drive_m(0, 32'h4000_0010, 32'hDEAD_BEEF, 1'b1, 4'hF, 1'b0);
      at_neg();
      acks += int'(m0_wb_ack_o); m1acks += int'(m1_wb_ack_o);
      checks++;
      if (s_wb_cyc_o !== 1'b0) begin
         errors++; $display("FAIL sw_cyc_fall got=%b exp=0", s_wb_cyc_o);
      end
      tick(); at_neg();
      checks++;
      if ({o_grant, o_busy} !== 3'b000) begin
         errors++; $display("FAIL sw_release got=%b exp=000", {o_grant, o_busy});
      end
      checks++;
      if (acks != 1 || m1acks != 0) begin
         errors++; $display("FAIL sw_ack_count got=%0d/%0d exp=1/0", acks, m1acks);
      end
   endtask

   task automatic test_tie_rr();
      do_reset();
      drive_m(0, $urandom, $urandom, 1'b1, 4'hF, 1'b1);
      drive_m(1, $urandom, $urandom, 1'b0, 4'hF, 1'b1);
      tick();
      s_wb_ack_i = 1'b1;
      at_neg();
      checks++;
      if ({o_grant, m0_wb_ack_o, m1_wb_ack_o} !== 4'b0110) begin
         errors++; $display("FAIL tie1_m0_first got=%b exp=0110", {o_grant, m0_wb_ack_o, m1_wb_ack_o});
      end
      tick();
      s_wb_ack_i = 1'b0;
      m0_wb_cyc_i = 1'b0; m0_wb_stb_i = 1'b0;
      at_neg();
      checks++;
      if (o_grant !== 2'b01) begin
         errors++; $display("FAIL tie1_hold got=%b exp=01", o_grant);
      end
      tick(); at_neg();
      checks++;
      if (o_grant !== 2'b00) begin
         errors++; $display("FAIL tie1_gap got=%b exp=00", o_grant);
      end
      tick();
      s_wb_ack_i = 1'b1;
      at_neg();
      checks++;
      if (o_grant !== 2'b10) begin
         errors++; $display("FAIL tie1_m1_next got=%b exp=10", o_grant);
      end
      tick();
      s_wb_ack_i = 1'b0;
      m1_wb_cyc_i = 1'b0; m1_wb_stb_i = 1'b0;
      tick();
      // lone master 0 transfer so that master 0 is the most recent winner
      drive_m(0, $urandom, $urandom, 1'b1, 4'hF, 1'b1);
      tick();
      s_wb_ack_i = 1'b1;
      at_neg();
      checks++;
      if (o_grant !== 2'b01) begin
         errors++; $display("FAIL solo_m0 got=%b exp=01", o_grant);
      end
      tick();
      s_wb_ack_i = 1'b0;
      m0_wb_cyc_i = 1'b0; m0_wb_stb_i = 1'b0;
      tick();
      drive_m(0, $urandom, $urandom, 1'b1, 4'hF, 1'b1);
      drive_m(1, $urandom, $urandom, 1'b1, 4'hF, 1'b1);
      tick(); at_neg();
      checks++;
      if (o_grant !== 2'b10) begin
         errors++; $display("FAIL tie3_m1_first got=%b exp=10", o_grant);
      end
      s_wb_ack_i = 1'b1;
      tick();
      s_wb_ack_i = 1'b0;
      m1_wb_cyc_i = 1'b0; m1_wb_stb_i = 1'b0;
      tick(); tick(); at_neg();
      checks++;
      if (o_grant !== 2'b01) begin
         errors++; $display("FAIL tie3_m0_second got=%b exp=01", o_grant);
      end
      s_wb_ack_i = 1'b1;
      tick();
      idle_all();
      tick(); tick();
   endtask

   task automatic test_burst_hold();
      logic [AW-1:0] base;
      base = AW'($urandom) & 32'hFFFF_FF00;
      drive_m(1, base, '0, 1'b0, 4'hF, 1'b1);
      tick();
      drive_m(0, $urandom, $urandom, 1'b1, 4'hF, 1'b1);
      for (int i = 0; i < 4; i++) begin
         int st = $urandom_range(0, 2);
         m1_wb_adr_i = base + AW'(4 * i);
         for (int s = 0; s < st; s++) begin
            at_neg();
            checks++;
            if ({o_grant, m0_wb_ack_o, m1_wb_ack_o} !== 4'b1000) begin
               errors++; $display("FAIL burst_stall got=%b exp=1000", {o_grant, m0_wb_ack_o, m1_wb_ack_o});
            end
            tick();
         end
         s_wb_ack_i = 1'b1;
         s_wb_dat_i = DW'(i + 1);
         at_neg();
         checks++;
         if (m1_wb_ack_o !== 1'b1 || m1_wb_dat_o !== DW'(i + 1)) begin
            errors++; $display("FAIL burst_data[%0d] got=%b/%h exp=1/%h", i, m1_wb_ack_o, m1_wb_dat_o, DW'(i + 1));
         end
         checks++;
         if ({o_grant, m0_wb_ack_o} !== 3'b100 || s_wb_adr_o !== base + AW'(4 * i)) begin
            errors++; $display("FAIL burst_owner[%0d] got=%b/%h exp=100/%h", i, {o_grant, m0_wb_ack_o},
                               s_wb_adr_o, base + AW'(4 * i));
         end
         tick();
         s_wb_ack_i = 1'b0;
      end
      m1_wb_cyc_i = 1'b0; m1_wb_stb_i = 1'b0;
      at_neg();
      checks++;
      if (o_grant !== 2'b10) begin
         errors++; $display("FAIL burst_drop_cycle got=%b exp=10", o_grant);
      end
      tick(); at_neg();
      checks++;
      if (o_grant !== 2'b00) begin
         errors++; $display("FAIL burst_gap got=%b exp=00", o_grant);
      end
      tick(); at_neg();
      checks++;
      if (o_grant !== 2'b01) begin
         errors++; $display("FAIL burst_m0_after got=%b exp=01", o_grant);
      end
      s_wb_ack_i = 1'b1;
      tick();
      idle_all();
      tick(); tick();
   endtask

   task automatic test_err();
      drive_m(0, $urandom, '0, 1'b0, 4'hF, 1'b1);
      tick(); tick();
      s_wb_err_i = 1'b1;
      at_neg();
      checks++;
      if ({m0_wb_err_o, m0_wb_ack_o, m1_wb_err_o, o_timeout, o_grant} !== 6'b100001) begin
         errors++; $display("FAIL err_route got=%b exp=100001",
                            {m0_wb_err_o, m0_wb_ack_o, m1_wb_err_o, o_timeout, o_grant});
      end
      tick();
      s_wb_err_i = 1'b0;
      at_neg();
      checks++;
      if ({m0_wb_err_o, s_wb_cyc_o, o_grant} !== 4'b0101) begin
         errors++; $display("FAIL err_hold got=%b exp=0101", {m0_wb_err_o, s_wb_cyc_o, o_grant});
      end
      tick();
      m0_wb_cyc_i = 1'b0; m0_wb_stb_i = 1'b0;
      tick(); at_neg();
      checks++;
      if ({o_grant, o_busy, o_timeout} !== 4'b0000) begin
         errors++; $display("FAIL err_release got=%b exp=0000", {o_grant, o_busy, o_timeout});
      end
   endtask

`ifdef WB_ARB_TIMEOUT_EN
   task automatic test_timeout();
      drive_m(0, $urandom, '0, 1'b0, 4'hF, 1'b1);
      tick();
      for (int k = 1; k <= 8; k++) begin
         at_neg();
         checks++;
         if ({s_wb_stb_o, m0_wb_err_o, o_timeout} !== 3'b100) begin
            errors++; $display("FAIL to_stall[%0d] got=%b exp=100", k, {s_wb_stb_o, m0_wb_err_o, o_timeout});
         end
         tick();
      end
      at_neg();
      checks++;
      if ({s_wb_cyc_o, s_wb_stb_o, m0_wb_err_o, m1_wb_err_o, o_timeout} !== 5'b00101) begin
         errors++; $display("FAIL to_abort got=%b exp=00101",
                            {s_wb_cyc_o, s_wb_stb_o, m0_wb_err_o, m1_wb_err_o, o_timeout});
      end
      tick(); at_neg();
      checks++;
      if ({s_wb_cyc_o, m0_wb_err_o, o_timeout, o_busy} !== 4'b0001) begin
         errors++; $display("FAIL to_drain got=%b exp=0001", {s_wb_cyc_o, m0_wb_err_o, o_timeout, o_busy});
      end
      tick();
      m0_wb_cyc_i = 1'b0; m0_wb_stb_i = 1'b0;
      tick(); at_neg();
      checks++;
      if ({o_grant, o_busy} !== 3'b000) begin
         errors++; $display("FAIL to_idle got=%b exp=000", {o_grant, o_busy});
      end
      // response on the very last allowed stall cycle must win
      drive_m(0, $urandom, '0, 1'b0, 4'hF, 1'b1);
      tick();
      for (int k = 1; k <= 7; k++) tick();
      s_wb_ack_i = 1'b1;
      at_neg();
      checks++;
      if ({m0_wb_ack_o, m0_wb_err_o} !== 2'b10) begin
         errors++; $display("FAIL to_ack8 got=%b exp=10", {m0_wb_ack_o, m0_wb_err_o});
      end
      tick();
      s_wb_ack_i = 1'b0;
      at_neg();
      checks++;
      if ({o_timeout, m0_wb_err_o, s_wb_cyc_o} !== 3'b001) begin
         errors++; $display("FAIL to_no_abort got=%b exp=001", {o_timeout, m0_wb_err_o, s_wb_cyc_o});
      end
      tick();
      idle_all();
      tick(); tick();
   endtask
`endif

   task automatic test_reset_mid();
      drive_m(1, $urandom, $urandom, 1'b1, 4'hF, 1'b1);
      tick(); at_neg();
      checks++;
      if (o_grant !== 2'b10) begin
         errors++; $display("FAIL rm_grant got=%b exp=10", o_grant);
      end
      tick();
      s_wb_ack_i = 1'b1;
      #2;
      i_resetn = 1'b0;
      #1;
      checks++;
      if (w_rst_vec !== 11'b0) begin
         errors++; $display("FAIL rm_async_clear got=%b exp=%b", w_rst_vec, 11'b0);
      end
      tick();
      idle_all();
      tick();
      i_resetn = 1'b1;
      tick();
      drive_m(0, $urandom, $urandom, 1'b1, 4'hF, 1'b1);
      drive_m(1, $urandom, $urandom, 1'b1, 4'hF, 1'b1);
      tick(); at_neg();
      checks++;
      if (o_grant !== 2'b01) begin
         errors++; $display("FAIL rm_tie_after got=%b exp=01", o_grant);
      end
      s_wb_ack_i = 1'b1;
      tick();
      idle_all();
      tick(); tick();
   endtask

   // masters issue random multi-beat bursts; expected owner follows the
   // arbitration rules applied to the requests visible each cycle
   task automatic test_random();
      int owner = -1;
      int last  = 1;
      int stall = 0;
      bit act[2], done[2], r0, r1;
      int beats[2];
      logic [AW-1:0] adr[2];
      logic [DW-1:0] dat[2];
      logic we[2];
      logic [1:0] exp_g;
      for (int n = 0; n < 2; n++) begin
         act[n] = 0; done[n] = 0; beats[n] = 0; adr[n] = '0; dat[n] = '0; we[n] = 1'b0;
      end
      do_reset();
      for (int c = 0; c < 600; c++) begin
         for (int n = 0; n < 2; n++) begin
            if (!act[n] && !done[n] && $urandom_range(0, 3) == 0) begin
               act[n] = 1; beats[n] = $urandom_range(1, 3);
               adr[n] = $urandom; dat[n] = $urandom; we[n] = 1'($urandom_range(0, 1));
            end
            done[n] = 0;
         end
         drive_m(0, adr[0], dat[0], we[0], 4'hF, act[0]);
         drive_m(1, adr[1], dat[1], we[1], 4'hF, act[1]);
         s_wb_dat_i = $urandom;
         s_wb_ack_i = 1'b0;
         if (owner >= 0 && act[owner]) begin
            if (stall >= 3 || $urandom_range(0, 1) == 1) begin
               s_wb_ack_i = 1'b1; stall = 0;
            end else begin
               stall++;
            end
         end
         at_neg();
         exp_g = (owner < 0) ? 2'b00 : ((owner == 0) ? 2'b01 : 2'b10);
         checks++;
         if (o_grant !== exp_g) begin
            errors++; $display("FAIL rnd_grant c=%0d got=%b exp=%b", c, o_grant, exp_g);
         end
         checks++;
         if ({m0_wb_ack_o, m1_wb_ack_o} !== {(owner == 0) && s_wb_ack_i, (owner == 1) && s_wb_ack_i}) begin
            errors++; $display("FAIL rnd_ack c=%0d got=%b%b owner=%0d ack=%b", c, m0_wb_ack_o, m1_wb_ack_o,
                               owner, s_wb_ack_i);
         end
         if (owner >= 0 && act[owner]) begin
            checks++;
            if (s_wb_adr_o !== adr[owner] || s_wb_cyc_o !== 1'b1 || m0_wb_dat_o !== s_wb_dat_i) begin
               errors++; $display("FAIL rnd_bus c=%0d got=%h/%b exp=%h/1", c, s_wb_adr_o, s_wb_cyc_o, adr[owner]);
            end
         end
         @(posedge i_clk);
         r0 = act[0];
         r1 = act[1];
         if (owner >= 0 && act[owner] && s_wb_ack_i) begin
            beats[owner]--;
            if (beats[owner] == 0) begin
               act[owner] = 0; done[owner] = 1;
            end
         end
         if (owner < 0) begin
            if (r0 && r1)  owner = 1 - last;
            else if (r0)   owner = 0;
            else if (r1)   owner = 1;
            if (owner >= 0) last = owner;
         end else if (!((owner == 0) ? r0 : r1)) begin
            owner = -1;
         end
         #1;
      end
      idle_all();
      tick(); tick();
   endtask

   initial begin
      idle_all();
      test_reset();
      test_single_write();
      test_tie_rr();
      test_burst_hold();
      test_err();
`ifdef WB_ARB_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire
